// File: rtl/noise_gate.sv
// Per-sample noise gate: tracks the envelope of the mic channel and applies a
// smoothed gain that fades hiss to zero before it reaches the echo stage.
// Runs on the I2S bit clock; each lrclk rising edge marks one sample.
module noise_gate #(
    parameter int BITSIZE      = 16,
    parameter int ATTACK_STEP  = 32,
    parameter int RELEASE_STEP = 1,
    parameter int HOLD_SAMPLES = 4800,
    parameter int ENV_SHIFT    = 6,
    parameter int HYST_SHIFT   = 3
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic                      lrclk,
    input  logic signed [BITSIZE-1:0] in,
    input  logic [BITSIZE-2:0]        threshold,
    input  logic                      enable,
    output logic signed [BITSIZE-1:0] out,
    output logic                      gate_open,
    output logic [8:0]                gain
);

    localparam int AW    = BITSIZE - 1;
    localparam int CNT_W = $clog2(HOLD_SAMPLES) + 1;

    typedef enum logic [2:0] {
        ST_CLOSED,
        ST_ATTACK,
        ST_OPEN,
        ST_HOLD,
        ST_RELEASE
    } state_t;

    state_t                     state_reg;
    logic                       lrclk_d_reg;
    logic                       stb;
    logic [AW-1:0]              abs_val;
    logic [AW-1:0]              env_reg;
    logic [AW-1:0]              env_next;
    logic [AW-1:0]              thr_lo;
    logic                       env_above;
    logic                       env_below;
    logic [8:0]                 gain_reg;
    logic [31:0]                gain_sum;
    logic [8:0]                 gain_inc;
    logic [8:0]                 gain_dec;
    logic [CNT_W-1:0]           hold_cnt_reg;
    logic                       gate_open_reg;
    logic signed [BITSIZE-1:0]  in_reg;
    logic signed [BITSIZE+9:0]  prod_reg;
    logic signed [BITSIZE-1:0]  out_reg;

    assign stb = lrclk & ~lrclk_d_reg;

    // Register lrclk so its rising edge becomes a one-cycle sample strobe.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            lrclk_d_reg <= 1'b0;
        end else begin
            lrclk_d_reg <= lrclk;
        end
    end

    // Saturating magnitude: the most negative sample maps to full scale
    // instead of wrapping to zero.
    always_comb begin
        abs_val = '0;
        if (!in[BITSIZE-1]) begin
            abs_val = in[AW-1:0];
        end else if (in == {1'b1, {(BITSIZE-1){1'b0}}}) begin
            abs_val = '1;
        end else begin
            abs_val = AW'(-in);
        end
    end

    // Peak-follow with exponential decay; decay can never go below zero.
    always_comb begin
        env_next = env_reg - (env_reg >> ENV_SHIFT);
        if (abs_val > env_reg) begin
            env_next = abs_val;
        end
    end

    // Hysteresis band and clamped gain steps used by the state machine.
    always_comb begin
        thr_lo    = threshold - (threshold >> HYST_SHIFT);
        env_above = (env_next > threshold);
        env_below = (env_next < thr_lo);
        gain_sum  = 32'(gain_reg) + 32'(ATTACK_STEP);
        gain_inc  = (gain_sum >= 32'd256) ? 9'd256 : gain_sum[8:0];
        gain_dec  = (32'(gain_reg) <= 32'(RELEASE_STEP)) ? 9'd0
                                                        : gain_reg - 9'(RELEASE_STEP);
    end

    // Gate state machine, envelope and gain; all advance once per sample.
    // A transition into ATTACK or RELEASE applies that state's step in the
    // same sample, so the ramp starts immediately.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_reg     <= ST_CLOSED;
            env_reg       <= '0;
            gain_reg      <= 9'd0;
            hold_cnt_reg  <= '0;
            gate_open_reg <= 1'b0;
        end else if (stb) begin
            env_reg <= env_next;
            if (!enable) begin
                state_reg     <= ST_OPEN;
                gain_reg      <= 9'd256;
                gate_open_reg <= 1'b1;
            end else begin
                case (state_reg)
                    ST_CLOSED: begin
                        if (env_above) begin
                            state_reg     <= ST_ATTACK;
                            gain_reg      <= gain_inc;
                            gate_open_reg <= 1'b1;
                        end else begin
                            gain_reg      <= 9'd0;
                            gate_open_reg <= 1'b0;
                        end
                    end
                    ST_ATTACK: begin
                        if (env_below) begin
                            state_reg     <= (gain_dec == 9'd0) ? ST_CLOSED : ST_RELEASE;
                            gain_reg      <= gain_dec;
                            gate_open_reg <= 1'b0;
                        end else begin
                            if (gain_inc == 9'd256) begin
                                state_reg <= ST_OPEN;
                            end
                            gain_reg      <= gain_inc;
                            gate_open_reg <= 1'b1;
                        end
                    end
                    ST_OPEN: begin
                        gain_reg      <= 9'd256;
                        gate_open_reg <= 1'b1;
                        if (env_below) begin
                            state_reg    <= ST_HOLD;
                            hold_cnt_reg <= CNT_W'(HOLD_SAMPLES - 1);
                        end
                    end
                    ST_HOLD: begin
                        if (env_above) begin
                            state_reg     <= ST_OPEN;
                            gain_reg      <= 9'd256;
                            gate_open_reg <= 1'b1;
                        end else if (hold_cnt_reg == '0) begin
                            state_reg     <= (gain_dec == 9'd0) ? ST_CLOSED : ST_RELEASE;
                            gain_reg      <= gain_dec;
                            gate_open_reg <= 1'b0;
                        end else begin
                            hold_cnt_reg  <= hold_cnt_reg - 1'b1;
                            gain_reg      <= 9'd256;
                            gate_open_reg <= 1'b1;
                        end
                    end
                    ST_RELEASE: begin
                        if (env_above) begin
                            state_reg     <= ST_ATTACK;
                            gain_reg      <= gain_inc;
                            gate_open_reg <= 1'b1;
                        end else begin
                            if (gain_dec == 9'd0) begin
                                state_reg <= ST_CLOSED;
                            end
                            gain_reg      <= gain_dec;
                            gate_open_reg <= 1'b0;
                        end
                    end
                    default: begin
                        state_reg     <= ST_CLOSED;
                        gain_reg      <= 9'd0;
                        gate_open_reg <= 1'b0;
                    end
                endcase
            end
        end
    end

    // Capture the sample on the strobe so the multiply sees a stable operand.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            in_reg <= '0;
        end else if (stb) begin
            in_reg <= in;
        end
    end

    // Two-stage output pipeline: product, then scale by 1/256.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            prod_reg <= '0;
            out_reg  <= '0;
        end else begin
            prod_reg <= in_reg * $signed({1'b0, gain_reg});
            out_reg  <= BITSIZE'(prod_reg >>> 8);
        end
    end

    assign out       = out_reg;
    assign gain      = gain_reg;
    assign gate_open = gate_open_reg;

endmodule

// File: tb/tb_noise_gate.sv
// Directed bench for noise_gate: table of per-frame vectors plus hand-written
// sequences for hold/release timing, retrigger, latency and edge values.
module tb_noise_gate;

    logic               clk;
    logic               reset_n;
    logic               lrclk;
    logic signed [15:0] in_v;
    logic [14:0]        thr;
    logic               en;
    logic signed [15:0] out_v;
    logic               gate_open;
    logic [8:0]         gain;

    int total;
    int bad;
    int env_m;

    typedef struct {
        logic signed [15:0] s;
        logic [8:0]         g;
        logic               o;
        logic signed [15:0] q;
    } vec_t;

    vec_t tbl[14];

    noise_gate dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .lrclk     (lrclk),
        .in        (in_v),
        .threshold (thr),
        .enable    (en),
        .out       (out_v),
        .gate_open (gate_open),
        .gain      (gain)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #5000000;
        $display("FAIL watchdog: time limit expired before test end");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end else begin
            $display("ok   %s: %0d", name, act);
        end
    endtask

    function automatic int abs_m(input int s);
        if (s == -32768) return 32767;
        return (s < 0) ? -s : s;
    endfunction

    task automatic env_upd(input int s);
        int a;
        a = abs_m(s);
        if (a > env_m) env_m = a;
        else env_m = env_m - (env_m >> 6);
    endtask

    // One sample frame: lrclk high for 2 clk, low for 2 clk; returns at a
    // falling edge after the output pipeline has settled.
    task automatic frame(input logic signed [15:0] s);
        @(negedge clk);
        in_v  = s;
        lrclk = 1'b1;
        repeat (2) @(negedge clk);
        lrclk = 1'b0;
        repeat (2) @(negedge clk);
        if (reset_n) env_upd(int'(s));
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset_n = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        env_m = 0;
    endtask

    initial begin
        int h;
        int err;
        int first_i;
        int first_g;
        int exp_g;
        int exp_o;
        bit reached;
        int rg[5];
        int rq[5];

        total = 0; bad = 0; env_m = 0;
        reset_n = 1'b0; lrclk = 1'b0; in_v = 16'sh7FFF; thr = 15'd1000; en = 1'b1;

        tbl[0]  = '{16'sd0,     9'd0,   1'b0, 16'sd0};
        tbl[1]  = '{16'sd0,     9'd0,   1'b0, 16'sd0};
        tbl[2]  = '{16'sd950,   9'd0,   1'b0, 16'sd0};
        tbl[3]  = '{16'sd950,   9'd0,   1'b0, 16'sd0};
        tbl[4]  = '{16'sd950,   9'd0,   1'b0, 16'sd0};
        tbl[5]  = '{16'sd8000,  9'd32,  1'b1, 16'sd1000};
        tbl[6]  = '{16'sd8000,  9'd64,  1'b1, 16'sd2000};
        tbl[7]  = '{16'sd8000,  9'd96,  1'b1, 16'sd3000};
        tbl[8]  = '{16'sd8000,  9'd128, 1'b1, 16'sd4000};
        tbl[9]  = '{16'sd8000,  9'd160, 1'b1, 16'sd5000};
        tbl[10] = '{16'sd8000,  9'd192, 1'b1, 16'sd6000};
        tbl[11] = '{16'sd8000,  9'd224, 1'b1, 16'sd7000};
        tbl[12] = '{16'sd8000,  9'd256, 1'b1, 16'sd8000};
        tbl[13] = '{-16'sd8000, 9'd256, 1'b1, -16'sd8000};

        // Reset held with full-scale input and a running frame clock.
        frame(16'sh7FFF);
        frame(16'sh7FFF);
        check("rst_out", int'(out_v), 0);
        check("rst_gain", int'(gain), 0);
        check("rst_open", int'(gate_open), 0);
        @(negedge clk);
        reset_n = 1'b1;

        // Idle, sub-threshold level from CLOSED, attack ramp, negative passthrough.
        for (int i = 0; i < 14; i++) begin
            frame(tbl[i].s);
            check($sformatf("vec%0d_gain", i), int'(gain), int'(tbl[i].g));
            check($sformatf("vec%0d_open", i), int'(gate_open), int'(tbl[i].o));
            check($sformatf("vec%0d_out", i), int'(out_v), int'(tbl[i].q));
        end

        // Hysteresis band while OPEN: the gate must never leave full gain.
        err = 0;
        for (int i = 0; i < 200; i++) begin
            frame(16'sd950);
            if (gain != 9'd256 || gate_open != 1'b1) err++;
        end
        check("hyst_open_drops", err, 0);
        check("hyst_gain", int'(gain), 256);
        check("hyst_out", int'(out_v), 950);

        // Silence: hold for HOLD_SAMPLES after env < 875, then release by 1.
        h = -1; err = 0; first_i = -1; first_g = 0; reached = 0;
        for (int i = 0; i < 6000; i++) begin
            frame(16'sd0);
            if (h < 0 && env_m < 875) h = i;
            if (h < 0 || i < h + 4800) begin
                exp_g = 256; exp_o = 1;
            end else begin
                exp_g = 256 - (i - h - 4799); exp_o = 0;
            end
            if (int'(gain) != exp_g || int'(gate_open) != exp_o) begin
                if (first_i < 0) begin first_i = i; first_g = int'(gain); end
                err++;
            end
            if (exp_g == 100) begin
                reached = 1;
                break;
            end
        end
        if (err != 0) $display("first hold/release deviation at frame %0d gain %0d", first_i, first_g);
        check("hold_release_errors", err, 0);
        check("hold_release_reached", int'(reached), 1);
        check("release_gain_100", int'(gain), 100);
        check("release_open", int'(gate_open), 0);

        // Retrigger in RELEASE: ramp continues upward from 100.
        rg = '{132, 164, 196, 228, 256};
        rq = '{4125, 5125, 6125, 7125, 8000};
        for (int i = 0; i < 5; i++) begin
            frame(16'sd8000);
            check($sformatf("retrig%0d_gain", i), int'(gain), rg[i]);
            check($sformatf("retrig%0d_open", i), int'(gate_open), 1);
            check($sformatf("retrig%0d_out", i), int'(out_v), rq[i]);
        end

        // Asynchronous reset in the middle of a frame clears outputs at once.
        @(negedge clk);
        lrclk = 1'b1;
        @(posedge clk);
        #2;
        reset_n = 1'b0;
        #1;
        check("midrst_gain", int'(gain), 0);
        check("midrst_open", int'(gate_open), 0);
        check("midrst_out", int'(out_v), 0);
        @(negedge clk);
        lrclk = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        env_m = 0;

        // Forced passthrough from gain 0, with exact two-clock output latency.
        @(negedge clk);
        en = 1'b0; in_v = 16'sd1234; lrclk = 1'b1;
        @(negedge clk);
        check("bypass_gain", int'(gain), 256);
        check("bypass_out_t1", int'(out_v), 0);
        @(negedge clk);
        lrclk = 1'b0;
        check("bypass_out_t2", int'(out_v), 0);
        @(negedge clk);
        check("bypass_out_t3", int'(out_v), 1234);
        @(negedge clk);
        env_upd(1234);

        // Re-enable resumes from OPEN rather than CLOSED.
        en = 1'b1;
        frame(16'sd0);
        check("reenable_gain", int'(gain), 256);
        check("reenable_open", int'(gate_open), 1);

        // Most negative input: magnitude saturates, so it exceeds 32766.
        do_reset();
        thr = 15'd32766;
        frame(-16'sd32768);
        check("sat_open", int'(gate_open), 1);
        check("sat_gain", int'(gain), 32);
        check("sat_out", int'(out_v), -4096);
        en = 1'b0;
        frame(-16'sd32768);
        check("minval_pass_gain", int'(gain), 256);
        check("minval_pass_out", int'(out_v), -32768);
        frame(16'sd32767);
        check("maxval_pass_out", int'(out_v), 32767);

        // Zero threshold: any nonzero input opens and keeps the gate open.
        do_reset();
        en = 1'b1; thr = 15'd0;
        frame(16'sd1);
        check("thr0_open", int'(gate_open), 1);
        check("thr0_gain", int'(gain), 32);
        frame(16'sd0);
        check("thr0_stay_open", int'(gate_open), 1);
        check("thr0_gain2", int'(gain), 64);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
